sobel_frame_writer: RTL and testbench

Downstream neighbour of the Sobel pipeline. Consumes the per-pixel RGB stream and its done strobe from the Sobel output. Writes each pixel of one ROWS x COLS frame into a linear frame buffer through a valid/ready memory write port. An elastic FIFO absorbs memory stalls. Reports frame completion and sticky overflow.

---
 rtl/sobel_frame_writer.sv | 119 +++++++++++
 tb/tb_sobel_frame_writer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_writer.sv
// Frame writer behind the Sobel pipeline: buffers strobed RGB pixels in a FWFT FIFO and writes
// one ROWS x COLS frame to memory. Optional macro SOBEL_WR_BINARIZE_EN stores red>=THRESH as white/black.
module sobel_frame_writer #(
  parameter int ROWS       = 400,
  parameter int COLS       = 400,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 18,
  parameter int BASE_ADDR  = 0,
  parameter int THRESH     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        red_i,
  input  logic [7:0]        green_i,
  input  logic [7:0]        blue_i,
  input  logic              done_i,
  input  logic              frame_start_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [23:0]       mem_data_o,
  output logic              mem_we_o,
  input  logic              mem_ready_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              overflow_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + 24;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [CW-1:0]     FULL_CNT = CW'(FIFO_DEPTH);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if ((THRESH < 0) || (THRESH > 255)) begin : g_bad_thresh
    $error("THRESH must fit in 8 bits");
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]     fifo_mem_q [FIFO_DEPTH];
  logic [EW-1:0]     push_entry, head;
  logic [23:0]       pixel;
  logic              push, pop, full, empty;

`ifdef SOBEL_WR_BINARIZE_EN
  assign pixel = (red_i >= 8'(THRESH)) ? 24'hFFFFFF : 24'h000000;
`else
  assign pixel = {red_i, green_i, blue_i};
`endif

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign pop        = !empty && mem_ready_i;
  // Address is fixed at push time so dropped pixels never shift later addresses.
  assign push_entry = {BASE + idx_q, pixel};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (frame_start_i) begin
        state_d = RUN;
        idx_d   = '0;
        ovf_d   = 1'b0;
      end
      RUN: if (done_i) begin
        idx_d = idx_q + 1'b1;
        if (full) ovf_d = 1'b1;
        else      push  = 1'b1;
        if (idx_q == LAST_IDX) state_d = FLUSH;
      end
      FLUSH: if (empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_entry;
  end

  assign head         = fifo_mem_q[rd_ptr_q];
  assign mem_we_o     = !empty;
  assign mem_addr_o   = empty ? '0 : head[EW-1:24];
  assign mem_data_o   = empty ? '0 : head[23:0];
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = (state_q == FLUSH) && empty;
  assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_sobel_frame_writer.sv
// Bench for sobel_frame_writer: directed and random frames checked against a queue-based model.
module tb_sobel_frame_writer;
  localparam int ROWS = 2, COLS = 3, DEPTH = 4, ADDR_W = 10, BASE = 100, THRESH = 64;
  localparam int NPIX = ROWS * COLS;
  localparam int EW = ADDR_W + 24;

  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] red_i = '0, green_i = '0, blue_i = '0;
  logic done_i = 1'b0, frame_start_i = 1'b0, mem_ready_i = 1'b1;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [23:0] mem_data_o;
  logic mem_we_o, busy_o, frame_done_o, overflow_o;

  sobel_frame_writer #(.ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W),
                       .BASE_ADDR(BASE), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .done_i(done_i), .frame_start_i(frame_start_i), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_we_o(mem_we_o), .mem_ready_i(mem_ready_i),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .overflow_o(overflow_o));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  // Model: 0 = idle, 1 = capturing, 2 = waiting for the buffer to empty.
  int mstate = 0, midx = 0;
  bit movf = 1'b0;
  logic [EW-1:0] q[$];

  function automatic logic [23:0] exp_pix(logic [7:0] r, logic [7:0] g, logic [7:0] b);
`ifdef SOBEL_WR_BINARIZE_EN
    return (int'(r) >= THRESH) ? 24'hFFFFFF : 24'h000000;
`else
    return {r, g, b};
`endif
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, advance the model with the current inputs, move past the edge.
  task automatic step();
    bit pop, push, full, empty0;
    logic [EW-1:0] e;
    @(negedge clk);
    chk("we", mem_we_o, q.size() != 0);
    if (q.size() != 0) begin
      chk("addr", mem_addr_o, q[0][EW-1:24]);
      chk("data", mem_data_o, q[0][23:0]);
    end
    chk("busy", busy_o, mstate != 0);
    chk("frame_done", frame_done_o, (mstate == 2) && (q.size() == 0));
    chk("overflow", overflow_o, movf);
    empty0 = (q.size() == 0);
    full   = (q.size() == DEPTH);
    pop    = !empty0 && mem_ready_i;
    push   = 1'b0;
    e      = '0;
    case (mstate)
      0: if (frame_start_i) begin mstate = 1; midx = 0; movf = 1'b0; end
      1: if (done_i) begin
        if (full) movf = 1'b1;
        else begin push = 1'b1; e = {ADDR_W'(BASE + midx), exp_pix(red_i, green_i, blue_i)}; end
        if (midx == NPIX - 1) mstate = 2;
        midx++;
      end
      default: if (empty0) mstate = 0;
    endcase
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic pix(logic [7:0] r, logic [7:0] g, logic [7:0] b);
    done_i = 1'b1; red_i = r; green_i = g; blue_i = b;
    step();
    done_i = 1'b0;
  endtask

  task automatic start();
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
  endtask

  task automatic drain(bit rnd);
    int n = 0;
    while ((mstate != 0 || q.size() != 0) && n < 300) begin
      if (rnd) mem_ready_i = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("drain_timeout", n < 300, 1);
    mem_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_we", mem_we_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", frame_done_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", mem_data_o, 0);
    q.delete(); mstate = 0; midx = 0; movf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    #1;
    chk("init_we", mem_we_o, 0);
    chk("init_busy", busy_o, 0);
    chk("init_ovf", overflow_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();

    // Basic frame at full throughput.
    start();
    for (int k = 1; k <= NPIX; k++) pix(8'(10 * k), 8'(10 * k), 8'(10 * k));
    drain(1'b0);
    step();

    // Strobes in idle are ignored.
    for (int k = 0; k < 5; k++) pix(8'($urandom), 8'($urandom), 8'($urandom));
    chk("idle_ovf", overflow_o, 0);

    // Backpressure: only DEPTH pixels fit, the rest drop.
    mem_ready_i = 1'b0;
    start();
    for (int k = 1; k <= NPIX; k++) pix(8'(k), 8'(k + 1), 8'(k + 2));
    repeat (3) step();
    chk("bp_ovf", overflow_o, 1);
    chk("bp_depth", q.size(), DEPTH);
    mem_ready_i = 1'b1;
    drain(1'b0);
    step();

    // Frame start mid-capture does not restart the index.
    start();
    pix(8'h11, 8'h22, 8'h33);
    pix(8'h44, 8'h55, 8'h66);
    frame_start_i = 1'b1;
    pix(8'h77, 8'h88, 8'h99);
    frame_start_i = 1'b0;
    for (int k = 0; k < 3; k++) pix(8'($urandom), 8'($urandom), 8'($urandom));
    drain(1'b0);

    // Reset mid-frame, then a fresh frame starts at BASE.
    mem_ready_i = 1'b0;
    start();
    for (int k = 0; k < 3; k++) pix(8'($urandom), 8'($urandom), 8'($urandom));
    do_reset();
    mem_ready_i = 1'b1;
    start();
    pix(8'd1, 8'd2, 8'd3);
    chk("post_rst_addr", mem_addr_o, BASE);
    for (int k = 0; k < NPIX - 1; k++) pix(8'($urandom), 8'($urandom), 8'($urandom));
    drain(1'b0);

    // Threshold boundary.
    start();
    pix(8'd63, 8'd63, 8'd63);
    pix(8'd64, 8'd64, 8'd64);
    pix(8'd64, 8'd0, 8'd255);
    pix(8'd63, 8'd255, 8'd0);
    pix(8'd0, 8'd200, 8'd1);
    pix(8'd255, 8'd1, 8'd200);
    drain(1'b0);

    // Random frames with random strobes, stalls and stray frame starts.
    for (int f = 0; f < 6; f++) begin
      int n = 0;
      start();
      while (mstate == 1 && n < 200) begin
        done_i        = 1'($urandom_range(0, 1));
        frame_start_i = ($urandom_range(0, 7) == 0);
        mem_ready_i   = ($urandom_range(0, 3) != 0) && (f != 5);
        red_i = 8'($urandom); green_i = 8'($urandom); blue_i = 8'($urandom);
        step();
        n++;
      end
      done_i = 1'b0; frame_start_i = 1'b0;
      chk("rand_timeout", n < 200, 1);
      drain(1'b1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
